// File: rtl/ram_port_arb_pkg.sv
//------------------------------------------------------------------------------
// ram_port_arb_pkg : shared types and defaults for the IFU/LSU RAM arbiter
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ram_port_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_REQ  = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_e;

   typedef enum logic {
      ARB_OWN_IFU = 1'b0,
      ARB_OWN_LSU = 1'b1
   } arb_own_e;

   localparam int ARB_TIMEOUT_DEF = 255;

endpackage

`default_nettype wire

// File: rtl/ram_port_arb_rr_arb2.sv
//------------------------------------------------------------------------------
// rr_arb2 : two-way round-robin pick between IFU and LSU (combinational)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arb2 (
   input  logic i_req_ifu,
   input  logic i_req_lsu,
   input  logic i_last_lsu,
   output logic o_valid,
   output logic o_win_lsu
);

   always_comb begin
      o_valid   = i_req_ifu | i_req_lsu;
      // On a tie the requester that did not win last time goes first.
      if (i_req_ifu && i_req_lsu) begin
         o_win_lsu = ~i_last_lsu;
      end else begin
         o_win_lsu = i_req_lsu;
      end
   end

endmodule

`default_nettype wire

// File: rtl/ram_port_arb.sv
//------------------------------------------------------------------------------
// ram_port_arb : shares one single-port RAM between IFU and LSU with timeout
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ram_port_arb
   import ram_port_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = ARB_TIMEOUT_DEF
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_ifu_req,
   input  logic [ADDR_WIDTH-1:0]   i_ifu_addr,
   output logic                    o_ifu_gnt,
   output logic                    o_ifu_rvalid,
   output logic [DATA_WIDTH-1:0]   o_ifu_rdata,
   input  logic                    i_lsu_req,
   input  logic                    i_lsu_wr_en,
   input  logic [ADDR_WIDTH-1:0]   i_lsu_addr,
   input  logic [DATA_WIDTH-1:0]   i_lsu_wr_data,
   input  logic [DATA_WIDTH/8-1:0] i_lsu_wr_mask,
   output logic                    o_lsu_gnt,
   output logic                    o_lsu_rvalid,
   output logic [DATA_WIDTH-1:0]   o_lsu_rdata,
   output logic                    o_ram_req,
   output logic                    o_ram_wr_en,
   output logic [ADDR_WIDTH-1:0]   o_ram_addr,
   output logic [DATA_WIDTH-1:0]   o_ram_wr_data,
   output logic [DATA_WIDTH/8-1:0] o_ram_wr_mask,
   input  logic                    i_ram_ready,
   input  logic                    i_ram_rvalid,
   input  logic [DATA_WIDTH-1:0]   i_ram_rdata,
   output logic                    o_err
);

   localparam int MASK_WIDTH = DATA_WIDTH / 8;
   localparam int CNT_WIDTH  = $clog2(TIMEOUT + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

   arb_state_e              state_q, state_d;
   arb_own_e                owner_q, owner_d;
   arb_own_e                last_q,  last_d;
   logic [CNT_WIDTH-1:0]    cnt_q,   cnt_d;
   logic                    wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;
   logic [DATA_WIDTH-1:0]   data_q,  data_d;
   logic [MASK_WIDTH-1:0]   mask_q,  mask_d;

   logic                    w_arb_valid;
   logic                    w_win_lsu;
   arb_own_e                w_winner;
   logic                    w_rvalid;
   logic [DATA_WIDTH-1:0]   w_rdata;

   rr_arb2 u_rr_arb2 (
      .i_req_ifu  (i_ifu_req),
      .i_req_lsu  (i_lsu_req),
      .i_last_lsu (last_q == ARB_OWN_LSU),
      .o_valid    (w_arb_valid),
      .o_win_lsu  (w_win_lsu)
   );

   assign w_winner = w_win_lsu ? ARB_OWN_LSU : ARB_OWN_IFU;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ARB_IDLE;
         owner_q <= ARB_OWN_IFU;
         last_q  <= ARB_OWN_LSU;
         cnt_q   <= '0;
         wr_en_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         wr_en_q <= wr_en_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         mask_q  <= mask_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      last_d        = last_q;
      cnt_d         = cnt_q;
      wr_en_d       = wr_en_q;
      addr_d        = addr_q;
      data_d        = data_q;
      mask_d        = mask_q;
      o_ifu_gnt     = 1'b0;
      o_lsu_gnt     = 1'b0;
      o_ram_req     = 1'b0;
      o_ram_wr_en   = 1'b0;
      o_ram_addr    = '0;
      o_ram_wr_data = '0;
      o_ram_wr_mask = '0;
      o_err         = 1'b0;
      w_rvalid      = 1'b0;
      w_rdata       = '0;

      case (state_q)
         ARB_IDLE: begin
            // Grant is Mealy, so it must also be held off while reset is asserted.
            if (w_arb_valid && !i_rst) begin
               state_d = ARB_REQ;
               owner_d = w_winner;
               last_d  = w_winner;
               if (w_winner == ARB_OWN_LSU) begin
                  o_lsu_gnt = 1'b1;
                  wr_en_d   = i_lsu_wr_en;
                  addr_d    = i_lsu_addr;
                  data_d    = i_lsu_wr_data;
                  mask_d    = i_lsu_wr_mask;
               end else begin
                  o_ifu_gnt = 1'b1;
                  wr_en_d   = 1'b0;
                  addr_d    = i_ifu_addr;
                  data_d    = '0;
                  mask_d    = '0;
               end
            end
         end
         ARB_REQ: begin
            o_ram_req     = 1'b1;
            o_ram_wr_en   = wr_en_q;
            o_ram_addr    = addr_q;
            o_ram_wr_data = data_q;
            o_ram_wr_mask = mask_q;
            if (i_ram_ready) begin
               cnt_d   = '0;
               state_d = wr_en_q ? ARB_IDLE : ARB_RESP;
            end
         end
         ARB_RESP: begin
            w_rdata = i_ram_rdata;
            if (i_ram_rvalid) begin
               w_rvalid = 1'b1;
               state_d  = ARB_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               w_rvalid = 1'b1;
               w_rdata  = '0;
               o_err    = 1'b1;
               state_d  = ARB_IDLE;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase

      o_ifu_rvalid = w_rvalid & (owner_q == ARB_OWN_IFU);
      o_lsu_rvalid = w_rvalid & (owner_q == ARB_OWN_LSU);
      o_ifu_rdata  = (owner_q == ARB_OWN_IFU) ? w_rdata : '0;
      o_lsu_rdata  = (owner_q == ARB_OWN_LSU) ? w_rdata : '0;
   end

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arb.sv
//------------------------------------------------------------------------------
// tb_ram_port_arb : scoreboard bench for ram_port_arb (directed + random rounds)
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_ram_port_arb;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int MW = DW / 8;
   localparam int TO = 4;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic          i_ifu_req = 1'b0;
   logic [AW-1:0] i_ifu_addr = '0;
   logic          o_ifu_gnt, o_ifu_rvalid;
   logic [DW-1:0] o_ifu_rdata;
   logic          i_lsu_req = 1'b0;
   logic          i_lsu_wr_en = 1'b0;
   logic [AW-1:0] i_lsu_addr = '0;
   logic [DW-1:0] i_lsu_wr_data = '0;
   logic [MW-1:0] i_lsu_wr_mask = '0;
   logic          o_lsu_gnt, o_lsu_rvalid;
   logic [DW-1:0] o_lsu_rdata;
   logic          o_ram_req, o_ram_wr_en;
   logic [AW-1:0] o_ram_addr;
   logic [DW-1:0] o_ram_wr_data;
   logic [MW-1:0] o_ram_wr_mask;
   logic          i_ram_ready = 1'b0;
   logic          i_ram_rvalid = 1'b0;
   logic [DW-1:0] i_ram_rdata = '0;
   logic          o_err;

   ram_port_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_ifu_req(i_ifu_req), .i_ifu_addr(i_ifu_addr), .o_ifu_gnt(o_ifu_gnt),
      .o_ifu_rvalid(o_ifu_rvalid), .o_ifu_rdata(o_ifu_rdata),
      .i_lsu_req(i_lsu_req), .i_lsu_wr_en(i_lsu_wr_en), .i_lsu_addr(i_lsu_addr),
      .i_lsu_wr_data(i_lsu_wr_data), .i_lsu_wr_mask(i_lsu_wr_mask), .o_lsu_gnt(o_lsu_gnt),
      .o_lsu_rvalid(o_lsu_rvalid), .o_lsu_rdata(o_lsu_rdata),
      .o_ram_req(o_ram_req), .o_ram_wr_en(o_ram_wr_en), .o_ram_addr(o_ram_addr),
      .o_ram_wr_data(o_ram_wr_data), .o_ram_wr_mask(o_ram_wr_mask),
      .i_ram_ready(i_ram_ready), .i_ram_rvalid(i_ram_rvalid), .i_ram_rdata(i_ram_rdata),
      .o_err(o_err)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   typedef struct { bit lsu; bit wr; logic [AW-1:0] addr; logic [DW-1:0] data; logic [MW-1:0] mask; } ram_exp_t;
   typedef struct { bit lsu; logic [DW-1:0] data; bit err; int at; } resp_t;
   typedef struct { int wait_n; int dly; logic [DW-1:0] data; } script_t;

   bit       gnt_q[$];   // expected grant order, 1 = LSU
   ram_exp_t ram_q[$];
   resp_t    resp_q[$];
   script_t  scr_q[$];

   int checks = 0;
   int errors = 0;
   int gnt_cyc = -10;
   bit last_m = 1'b1;    // requester served most recently (ties go to the other)
   bit rv_clear = 1'b0;
   bit ram_busy = 1'b0;

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic all_out_zero();
      return ~|{o_ifu_gnt, o_ifu_rvalid, o_ifu_rdata, o_lsu_gnt, o_lsu_rvalid, o_lsu_rdata,
                o_ram_req, o_ram_wr_en, o_ram_addr, o_ram_wr_data, o_ram_wr_mask, o_err};
   endfunction

   // Monitor: grants and read returns are popped from the scoreboard when seen.
   initial begin : monitor
      resp_t r;
      bit    g;
      forever begin
         @(negedge i_clk);
         #2;
         if (!i_rst) begin
            if (o_ifu_gnt || o_lsu_gnt) begin
               chk(!(o_ifu_gnt && o_lsu_gnt), "gnt_onehot", 64'({o_ifu_gnt, o_lsu_gnt}), 64'(1));
               if (gnt_q.size() == 0) begin
                  chk(1'b0, "gnt_unexpected", 64'(o_lsu_gnt), 64'(0));
               end else begin
                  g = gnt_q.pop_front();
                  chk(o_lsu_gnt == g, "gnt_owner_lsu", 64'(o_lsu_gnt), 64'(g));
               end
               gnt_cyc = cyc;
            end
            if (o_ifu_rvalid || o_lsu_rvalid) begin
               chk(!(o_ifu_rvalid && o_lsu_rvalid), "rvalid_onehot", 64'({o_ifu_rvalid, o_lsu_rvalid}), 64'(1));
               if (resp_q.size() == 0) begin
                  chk(1'b0, "rvalid_unexpected", 64'({o_ifu_rvalid, o_lsu_rvalid}), 64'(0));
               end else begin
                  r = resp_q.pop_front();
                  chk(o_lsu_rvalid == r.lsu, "resp_port_lsu", 64'(o_lsu_rvalid), 64'(r.lsu));
                  chk((r.lsu ? o_lsu_rdata : o_ifu_rdata) == r.data, "resp_data",
                      64'(r.lsu ? o_lsu_rdata : o_ifu_rdata), 64'(r.data));
                  chk(o_err == r.err, "resp_err", 64'(o_err), 64'(r.err));
                  chk(cyc == r.at, "resp_cycle", 64'(cyc), 64'(r.at));
                  chk((r.lsu ? o_ifu_rdata : o_lsu_rdata) == '0, "nonowner_rdata",
                      64'(r.lsu ? o_ifu_rdata : o_lsu_rdata), 64'(0));
               end
            end else if (o_err) begin
               chk(1'b0, "err_without_rvalid", 64'(o_err), 64'(0));
            end
         end
      end
   end

   // RAM model: checks the request payload, applies ready/rvalid timing and
   // pushes the response the owner must see (data, or timeout error).
   initial begin : ram_model
      ram_exp_t e;
      script_t  s;
      int       c1;
      forever begin
         @(negedge i_clk);
         if (rv_clear) begin
            i_ram_rvalid = 1'b0;
            rv_clear     = 1'b0;
         end
         i_ram_rdata = $urandom;
         if (o_ram_req && !i_rst) begin
            ram_busy = 1'b1;
            if (ram_q.size() == 0) begin
               chk(1'b0, "ram_req_unexpected", 64'(o_ram_addr), 64'(0));
               e = '{lsu: 1'b0, wr: 1'b1, addr: '0, data: '0, mask: '0};
            end else begin
               e = ram_q.pop_front();
            end
            if (scr_q.size() > 0) s = scr_q.pop_front();
            else s = '{wait_n: $urandom_range(0, 3), dly: $urandom_range(0, TO), data: $urandom};
            chk(cyc == gnt_cyc + 1, "req_latency", 64'(cyc), 64'(gnt_cyc + 1));
            chk(o_ram_wr_en == e.wr, "ram_wr_en", 64'(o_ram_wr_en), 64'(e.wr));
            chk(o_ram_addr == e.addr, "ram_addr", 64'(o_ram_addr), 64'(e.addr));
            chk(o_ram_wr_data == e.data, "ram_wr_data", 64'(o_ram_wr_data), 64'(e.data));
            chk(o_ram_wr_mask == e.mask, "ram_wr_mask", 64'(o_ram_wr_mask), 64'(e.mask));
            for (int k = 0; k < s.wait_n; k++) begin
               i_ram_ready = 1'b0;
               @(negedge i_clk);
               i_ram_rdata = $urandom;
               chk(o_ram_req && o_ram_addr == e.addr && o_ram_wr_data == e.data &&
                   o_ram_wr_mask == e.mask && o_ram_wr_en == e.wr,
                   "ram_hold", 64'(o_ram_addr), 64'(e.addr));
            end
            i_ram_ready = 1'b1;
            @(negedge i_clk);
            i_ram_ready = 1'b0;
            i_ram_rdata = $urandom;
            chk(!o_ram_req, "req_drop_after_ready", 64'(o_ram_req), 64'(0));
            if (!e.wr) begin
               c1 = cyc;
               if (s.dly < TO) resp_q.push_back('{lsu: e.lsu, data: s.data, err: 1'b0, at: c1 + s.dly});
               else            resp_q.push_back('{lsu: e.lsu, data: '0, err: 1'b1, at: c1 + TO - 1});
               if (s.dly <= TO) begin
                  repeat (s.dly) begin
                     @(negedge i_clk);
                     i_ram_rdata = $urandom;
                  end
                  i_ram_rvalid = 1'b1;
                  i_ram_rdata  = s.data;
                  rv_clear     = 1'b1;
               end
            end
            ram_busy = 1'b0;
         end
      end
   end

   task automatic round(input bit ri, input bit rl, input logic [AW-1:0] ia, input bit lw,
                        input logic [AW-1:0] la, input logic [DW-1:0] ld, input logic [MW-1:0] lm);
      bit order[$];
      bit pi, pl;
      int n;
      if (ri && rl) begin
         order.push_back(~last_m);
         order.push_back(last_m);
      end else begin
         order.push_back(rl);
      end
      foreach (order[k]) begin
         gnt_q.push_back(order[k]);
         if (order[k]) ram_q.push_back('{lsu: 1'b1, wr: lw, addr: la, data: ld, mask: lm});
         else          ram_q.push_back('{lsu: 1'b0, wr: 1'b0, addr: ia, data: '0, mask: '0});
      end
      last_m = order[order.size() - 1];
      @(negedge i_clk);
      i_ifu_req = ri; i_ifu_addr = ia;
      i_lsu_req = rl; i_lsu_wr_en = lw; i_lsu_addr = la; i_lsu_wr_data = ld; i_lsu_wr_mask = lm;
      pi = ri; pl = rl; n = 0;
      while ((pi || pl) && n < 200) begin
         #2;
         if (o_ifu_gnt) pi = 1'b0;
         if (o_lsu_gnt) pl = 1'b0;
         @(negedge i_clk);
         n++;
         // Scramble dropped inputs so the DUT must rely on its latched copy.
         if (!pi) begin i_ifu_req = 1'b0; i_ifu_addr = $urandom; end
         if (!pl) begin
            i_lsu_req = 1'b0; i_lsu_addr = $urandom; i_lsu_wr_data = $urandom;
            i_lsu_wr_en = 1'($urandom_range(0, 1)); i_lsu_wr_mask = MW'($urandom);
         end
      end
      if (pi || pl) begin
         chk(1'b0, "grant_timeout", 64'({pi, pl}), 64'(0));
         i_ifu_req = 1'b0;
         i_lsu_req = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((gnt_q.size() != 0 || ram_q.size() != 0 || resp_q.size() != 0 || ram_busy) && n < 300) begin
         @(negedge i_clk);
         n++;
      end
      if (n >= 300) chk(1'b0, "drain_timeout", 64'(resp_q.size()), 64'(0));
      repeat (3) @(negedge i_clk);
   endtask

   initial begin : stimulus
      bit [1:0] pat;
      // Reset: outputs quiet even with both requests high.
      i_ifu_req = 1'b1;
      i_lsu_req = 1'b1;
      repeat (3) @(negedge i_clk);
      #2;
      chk(all_out_zero(), "reset_outputs", 64'(~all_out_zero()), 64'(0));
      @(negedge i_clk);
      i_ifu_req = 1'b0;
      i_lsu_req = 1'b0;
      @(negedge i_clk);
      i_rst = 1'b0;

      // Tie twice from reset: IFU, LSU, IFU, LSU.
      round(1'b1, 1'b1, 32'h0000_0040, 1'b0, 32'h0000_0080, '0, '0);
      round(1'b1, 1'b1, 32'h0000_0044, 1'b1, 32'h0000_0084, 32'h5555_AAAA, 4'h3);
      wait_idle();

      // IFU read with zero wait, rvalid two cycles after the request.
      scr_q.push_back('{wait_n: 0, dly: 1, data: 32'hDEAD_BEEF});
      round(1'b1, 1'b0, 32'h8000_0000, 1'b0, '0, '0, '0);
      wait_idle();

      // LSU write held off by three not-ready cycles.
      scr_q.push_back('{wait_n: 3, dly: 0, data: '0});
      round(1'b0, 1'b1, '0, 1'b1, 32'h0000_0100, 32'h1122_3344, 4'hF);
      wait_idle();

      // LSU read with no RAM response: forced error on the TIMEOUT-th RESP cycle.
      scr_q.push_back('{wait_n: 0, dly: 99, data: '0});
      round(1'b0, 1'b1, '0, 1'b0, 32'h0000_0200, '0, '0);
      wait_idle();

      // Stray RAM rvalid while idle.
      @(negedge i_clk);
      i_ram_rvalid = 1'b1;
      i_ram_rdata  = 32'h0BAD_0BAD;
      #2;
      chk(!o_ifu_rvalid && !o_lsu_rvalid && !o_err, "idle_stray_rvalid",
          64'({o_ifu_rvalid, o_lsu_rvalid, o_err}), 64'(0));
      @(negedge i_clk);
      i_ram_rvalid = 1'b0;
      #2;
      chk(!o_ram_req, "idle_stays_idle", 64'(o_ram_req), 64'(0));
      wait_idle();

      // Reset while waiting in RESP; late rvalid afterwards is ignored.
      scr_q.push_back('{wait_n: 0, dly: 99, data: '0});
      round(1'b1, 1'b0, 32'h0000_0300, 1'b0, '0, '0, '0);
      repeat (2) @(negedge i_clk);
      i_rst = 1'b1;
      #2;
      chk(all_out_zero(), "reset_mid_resp", 64'(~all_out_zero()), 64'(0));
      resp_q.delete();
      last_m = 1'b1;
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);
      i_ram_rvalid = 1'b1;
      i_ram_rdata  = 32'hCAFE_F00D;
      #2;
      chk(!o_ifu_rvalid && !o_lsu_rvalid && !o_err, "late_rvalid_ignored",
          64'({o_ifu_rvalid, o_lsu_rvalid, o_err}), 64'(0));
      @(negedge i_clk);
      i_ram_rvalid = 1'b0;
      round(1'b1, 1'b1, 32'h0000_0400, 1'b0, 32'h0000_0500, '0, '0);
      wait_idle();

      // Randomized rounds.
      for (int r = 0; r < 60; r++) begin
         pat = 2'($urandom_range(1, 3));
         round(pat[0], pat[1], $urandom, 1'($urandom_range(0, 1)), $urandom, $urandom, MW'($urandom));
         repeat ($urandom_range(0, 2)) @(negedge i_clk);
      end
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule

`default_nettype wire
